digit_serial_addsub: RTL and testbench

DIGIT_SERIAL_ADDSUB -- requirements
Module: digit_serial_addsub

---
 rtl/digit_serial_addsub.sv | 121 ++++++++++++
 tb/tb_digit_serial_addsub.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub: digit-serial two's-complement adder/subtractor.
// Processes DIGIT bits per clock, least significant digit first.
// The result and flags become valid with a one-cycle done pulse,
// N = WIDTH/DIGIT cycles after the start is accepted.
// WIDTH must be an integer multiple of DIGIT, and DIGIT must be at least 1.
module digit_serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;

  // Operand shift registers.
  // The b register holds the operand already inverted for subtraction.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic [DIGIT-1:0]       a_dig;
  logic [DIGIT-1:0]       b_dig;
  logic [DIGIT:0]         dsum;
  logic [WIDTH+DIGIT-1:0] res_shift;
  logic [WIDTH-1:0]       result_d;
  logic                   msb_cin;

  // Per-digit adder.
  // The new digit enters the result at the top, so after N shifts
  // the first digit ends up at the bottom.
  always_comb begin
    a_dig     = a_q[DIGIT-1:0];
    b_dig     = b_q[DIGIT-1:0];
    dsum      = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    res_shift = {dsum[DIGIT-1:0], result_q};
    result_d  = res_shift[WIDTH+DIGIT-1:DIGIT];
    // Carry into the digit MSB, recovered from sum = a ^ b ^ cin.
    // On the last digit this is the carry into bit WIDTH-1.
    msb_cin   = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ dsum[DIGIT-1];
  end

  // Control FSM together with the operand, result and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub;
            cnt_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q      <= a_q >> DIGIT;
          b_q      <= b_q >> DIGIT;
          result_q <= result_d;
          carry_q  <= dsum[DIGIT];
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            cout_q  <= dsum[DIGIT];
            ovf_q   <= msb_cin ^ dsum[DIGIT];
            zero_q  <= (result_d == '0);
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Testbench for digit_serial_addsub (WIDTH=16, DIGIT=4).
// A driver issues directed operations and queues the expected response.
// A monitor compares each done pulse against the head of the queue.
module tb_digit_serial_addsub;

  localparam int W = 16;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic         sub   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         zero;

  digit_serial_addsub #(.WIDTH(W), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
    int           edge_exp;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
  } vec_t;

  exp_t sb[$];
  int   edge_n   = 0;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  // Count rising edges.
  // After edge k, at the following falling edge, edge_n == k.
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Monitor: compare every done pulse with the oldest expected response.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result",  32'(result), 32'(e.res));
        chk("cout",    32'(cout),   32'(e.c));
        chk("ovf",     32'(ovf),    32'(e.v));
        chk("zero",    32'(zero),   32'(e.z));
        chk("latency", 32'(edge_n), 32'(e.edge_exp));
        $display("op done: result=%h cout=%b ovf=%b zero=%b at edge %0d",
                 result, cout, ovf, zero, edge_n);
      end
    end
  end

  task automatic push_exp(input logic [W-1:0] r, input logic c, input logic v,
                          input logic z, input int edge_exp);
    exp_t e;
    e.res = r; e.c = c; e.v = v; e.z = z; e.edge_exp = edge_exp;
    sb.push_back(e);
  endtask

  // Drive one start pulse.
  // Returns at the falling edge after the accept edge, with acc set to that edge number.
  task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic si, output int acc);
    @(negedge clk);
    a = ai; b = bi; sub = si; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    acc = edge_n;
    chk("accept_busy", 32'(busy), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   32'(busy),   32'd0);
    chk({tag, "_done"},   32'(done),   32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_cout"},   32'(cout),   32'd0);
    chk({tag, "_ovf"},    32'(ovf),    32'd0);
    chk({tag, "_zero"},   32'(zero),   32'd0);
  endtask

  vec_t vecs[5] = '{
    '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0},
    '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1},
    '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0},
    '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0},
    '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0}
  };

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int d0;

    // Reset must win over a simultaneous start.
    rst = 1'b1; start = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Directed vectors. The last one leaves nonzero flags before the reset-abort test.
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].s, acc);
      push_exp(vecs[i].res, vecs[i].c, vecs[i].v, vecs[i].z, acc + 4);
      repeat (5) @(negedge clk);
    end

    // Reset after the second RUN edge aborts the operation with no done pulse.
    d0 = done_cnt;
    issue(16'hAAAA, 16'h5555, 1'b0, acc);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("abort");
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

    issue(16'h0005, 16'h0005, 1'b1, acc);
    push_exp(16'h0000, 1'b1, 1'b0, 1'b1, acc + 4);
    repeat (5) @(negedge clk);

    // Toggle start and change the operands while busy.
    // Exactly one done pulse must occur, and the result must come from the captured operands.
    d0 = done_cnt;
    issue(16'h1111, 16'h2222, 1'b0, acc);
    push_exp(16'h3333, 1'b0, 1'b0, 1'b0, acc + 4);
    start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'h0000;
    @(negedge clk);
    start = 1'b1; b = 16'h8000;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("single_done", 32'(done_cnt - d0), 32'd1);

    // Back-to-back: a start held during DONE is accepted in that cycle.
    issue(16'h00FF, 16'h0001, 1'b0, acc);
    push_exp(16'h0100, 1'b0, 1'b0, 1'b0, acc + 4);
    repeat (4) @(negedge clk);
    chk("b2b_in_done", 32'(done), 32'd1);
    a = 16'h0010; b = 16'h0020; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    push_exp(16'hFFF0, 1'b0, 1'b0, 1'b0, acc + 9);
    repeat (6) @(negedge clk);

    // Drain: every queued response must have been observed.
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
